// File: rtl/read_div_pkg.sv
// -----------------------------------------------------------------------------
// read_div_pkg
// Shared definitions for the approximate-divider sequencing controller:
//   - controller state enum
//   - geometry constants (level width, row-mask width, number of rows)
//   - default divide-by-zero quotient
//   - level -> row-mask map and an 8-bit absolute-difference helper
// -----------------------------------------------------------------------------
package read_div_pkg;

  localparam int LEVEL_W = 3;
  localparam int MASK_W  = 8;
  localparam int ROWS    = 8;

  localparam logic [7:0] DZ_QUOT_DEF = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_RECHECK = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Row i (1-based) loses its low max(0, i+L-7) cells, capped at the full row.
  // Level 0 keeps every row exact.
  function automatic logic [ROWS*MASK_W-1:0] level_to_mask(input logic [LEVEL_W-1:0] level);
    logic [ROWS*MASK_W-1:0] m;
    int sh;
    m = {(ROWS*MASK_W){1'b1}};
    for (int i = 1; i <= ROWS; i++) begin
      sh = (level == {LEVEL_W{1'b0}}) ? 32'sd0 : (i + int'(level) - 32'sd7);
      sh = (sh < 32'sd0) ? 32'sd0 : ((sh > MASK_W) ? MASK_W : sh);
      m[(i-1)*MASK_W +: MASK_W] = 8'hFF << sh;
    end
    return m;
  endfunction

  function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/read_div_ctrl_if.sv
// -----------------------------------------------------------------------------
// read_div_ctrl_if
// Bundles the three buses around the controller:
//   job side     : in_valid/in_ready, in_x, in_y, in_level
//   divider side : div_x, div_y, div_bin, div_app -> divider; div_q, div_r <- divider
//   result side  : out_valid/out_ready, out_q, out_r, out_dz, out_ovf, out_err
// slave  : controller view
// master : environment view (job source, divider, consumer)
// -----------------------------------------------------------------------------
interface read_div_ctrl_if;
  import read_div_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [15:0]            in_x;
  logic [7:0]             in_y;
  logic [LEVEL_W-1:0]     in_level;

  logic [15:0]            div_x;
  logic [7:0]             div_y;
  logic                   div_bin;
  logic [ROWS*MASK_W-1:0] div_app;
  logic [7:0]             div_q;
  logic [7:0]             div_r;

  logic                   out_valid;
  logic                   out_ready;
  logic [7:0]             out_q;
  logic [7:0]             out_r;
  logic                   out_dz;
  logic                   out_ovf;
  logic [7:0]             out_err;

  modport slave (
    input  in_valid, in_x, in_y, in_level, div_q, div_r, out_ready,
    output in_ready, div_x, div_y, div_bin, div_app,
           out_valid, out_q, out_r, out_dz, out_ovf, out_err
  );

  modport master (
    output in_valid, in_x, in_y, in_level, div_q, div_r, out_ready,
    input  in_ready, div_x, div_y, div_bin, div_app,
           out_valid, out_q, out_r, out_dz, out_ovf, out_err
  );

endinterface

// File: rtl/read_div_mask_gen.sv
// -----------------------------------------------------------------------------
// read_div_mask_gen
// Combinational map from approximation level to the eight divider row masks.
//   i_level : approximation level, 0 = exact
//   o_app   : row masks, app1 = [7:0] ... app8 = [63:56]
// -----------------------------------------------------------------------------
module read_div_mask_gen
  import read_div_pkg::*;
(
  input  logic [LEVEL_W-1:0]     i_level,
  output logic [ROWS*MASK_W-1:0] o_app
);

  assign o_app = level_to_mask(i_level);

endmodule

// File: rtl/read_div_ctrl.sv
// -----------------------------------------------------------------------------
// read_div_ctrl
// Sequences one combinational 16x8 approximate array divider: accepts a job,
// drives the divider from registered operands and row masks, waits
// SETTLE_CYCLES, then registers q/r and offers them to the consumer.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : read_div_ctrl_if.slave (job, divider and result buses)
// Parameters:
//   SETTLE_CYCLES : cycles the divider inputs are held before sampling (1..15)
//   DZ_QUOT       : quotient reported for a zero divisor
// Optional build macro READ_DIV_RECHECK_EN: for non-zero levels, re-run the
// divider exactly after the approximate pass and report |q_exact - q_approx|
// on out_err; without it out_err stays 0.
// -----------------------------------------------------------------------------
module read_div_ctrl
  import read_div_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  DZ_QUOT       = DZ_QUOT_DEF
)(
  input  logic           clk,
  input  logic           rst,
  read_div_ctrl_if.slave bus
);

  localparam logic [3:0] C_SETTLE = 4'(SETTLE_CYCLES);

  state_t                 r_state;
  state_t                 w_state;
  logic [3:0]             r_cnt;
  logic                   w_accept;
  logic                   w_capture;
  logic                   w_rechk_start;
  logic                   w_release;
  logic [ROWS*MASK_W-1:0] w_mask;

  logic [15:0]            r_x;
  logic [7:0]             r_y;
  logic [15:0]            r_div_x;
  logic [7:0]             r_div_y;
  logic [ROWS*MASK_W-1:0] r_div_app;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [7:0]             r_out_q;
  logic [7:0]             r_out_r;
  logic                   r_out_dz;
  logic                   r_out_ovf;
  logic [7:0]             r_out_err;
`ifdef READ_DIV_RECHECK_EN
  logic [LEVEL_W-1:0]     r_level;
  logic [7:0]             r_q_apx;
  logic [7:0]             r_r_apx;
`endif

  read_div_mask_gen u_mask_gen (
    .i_level (bus.in_level),
    .o_app   (w_mask)
  );

  // Next-state decode and the per-edge action strobes.
  always_comb begin
    w_state       = r_state;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_rechk_start = 1'b0;
    w_release     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_accept = 1'b1;
          w_state  = ST_SETTLE;
        end else begin
          w_state  = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == 4'd1) begin
`ifdef READ_DIV_RECHECK_EN
          if ((r_level != {LEVEL_W{1'b0}}) && (r_y != 8'd0)) begin
            w_rechk_start = 1'b1;
            w_state       = ST_RECHECK;
          end else begin
            w_capture     = 1'b1;
            w_state       = ST_DONE;
          end
`else
          w_capture = 1'b1;
          w_state   = ST_DONE;
`endif
        end else begin
          w_state = ST_SETTLE;
        end
      end
`ifdef READ_DIV_RECHECK_EN
      ST_RECHECK: begin
        if (r_cnt == 4'd1) begin
          w_capture = 1'b1;
          w_state   = ST_DONE;
        end else begin
          w_state   = ST_RECHECK;
        end
      end
`endif
      ST_DONE: begin
        if (r_out_valid && bus.out_ready) begin
          w_release = 1'b1;
          w_state   = ST_IDLE;
        end else begin
          w_state   = ST_DONE;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  // State register and settle counter; a zero divisor waits one cycle only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state;
      if (w_accept) begin
        r_cnt <= (bus.in_y == 8'd0) ? 4'd1 : C_SETTLE;
      end else if (w_rechk_start) begin
        r_cnt <= C_SETTLE;
      end else if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Operand latch, divider drive registers and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= 16'd0;
      r_y         <= 8'd0;
      r_div_x     <= 16'd0;
      r_div_y     <= 8'd0;
      r_div_app   <= {(ROWS*MASK_W){1'b1}};
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_q     <= 8'd0;
      r_out_r     <= 8'd0;
      r_out_dz    <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_err   <= 8'd0;
`ifdef READ_DIV_RECHECK_EN
      r_level     <= {LEVEL_W{1'b0}};
      r_q_apx     <= 8'd0;
      r_r_apx     <= 8'd0;
`endif
    end else begin
      r_in_ready <= (w_state == ST_IDLE);
      if (w_accept) begin
        r_x <= bus.in_x;
        r_y <= bus.in_y;
`ifdef READ_DIV_RECHECK_EN
        r_level <= bus.in_level;
`endif
        // A zero divisor never exercises the divider, so its drive is left alone.
        if (bus.in_y != 8'd0) begin
          r_div_x   <= bus.in_x;
          r_div_y   <= bus.in_y;
          r_div_app <= w_mask;
        end
      end
`ifdef READ_DIV_RECHECK_EN
      if (w_rechk_start) begin
        r_q_apx   <= bus.div_q;
        r_r_apx   <= bus.div_r;
        r_div_app <= {(ROWS*MASK_W){1'b1}};
      end
`endif
      if (w_capture) begin
        r_out_valid <= 1'b1;
        if (r_y == 8'd0) begin
          r_out_q   <= DZ_QUOT;
          r_out_r   <= r_x[7:0];
          r_out_dz  <= 1'b1;
          r_out_ovf <= 1'b0;
          r_out_err <= 8'd0;
        end else begin
          r_out_dz  <= 1'b0;
          r_out_ovf <= (r_x[15:8] >= r_y);
`ifdef READ_DIV_RECHECK_EN
          if (r_state == ST_RECHECK) begin
            r_out_q   <= r_q_apx;
            r_out_r   <= r_r_apx;
            r_out_err <= abs_diff8(bus.div_q, r_q_apx);
          end else begin
            r_out_q   <= bus.div_q;
            r_out_r   <= bus.div_r;
            r_out_err <= 8'd0;
          end
`else
          r_out_q   <= bus.div_q;
          r_out_r   <= bus.div_r;
          r_out_err <= 8'd0;
`endif
        end
      end else if (w_release) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.div_x     = r_div_x;
  assign bus.div_y     = r_div_y;
  assign bus.div_bin   = 1'b0;
  assign bus.div_app   = r_div_app;
  assign bus.out_valid = r_out_valid;
  assign bus.out_q     = r_out_q;
  assign bus.out_r     = r_out_r;
  assign bus.out_dz    = r_out_dz;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_read_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_read_div_ctrl
// Self-checking bench for read_div_ctrl: a behavioural divider model answers
// the controller, a job-level reference model predicts every output on every
// cycle, and directed jobs pin literal results.
// -----------------------------------------------------------------------------
module tb_read_div_ctrl;
  import read_div_pkg::*;

  localparam int S = 2;
`ifdef READ_DIV_RECHECK_EN
  localparam bit RCHK = 1'b1;
`else
  localparam bit RCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  read_div_ctrl_if bus();

  read_div_ctrl #(.SETTLE_CYCLES(S), .DZ_QUOT(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Row masks: row i clears its low (i+L-7) bits, clamped to 0..8.
  function automatic logic [63:0] ref_masks(input int lvl);
    logic [63:0] m;
    int z;
    for (int row = 0; row < 8; row++) begin
      z = (lvl == 0) ? 0 : (row + 1) + lvl - 7;
      if (z < 0) z = 0;
      if (z > 8) z = 8;
      m[row*8 +: 8] = 8'(255 - ((1 << z) - 1));
    end
    return m;
  endfunction

  // Divider model: exact divide; a fully masked row i loses quotient bit 8-i.
  function automatic logic [15:0] div_model(input logic [15:0] x, input logic [7:0] y,
                                            input logic [63:0] app);
    int q;
    int r;
    if (y == 8'd0) begin
      q = 255;
      r = int'(x);
    end else begin
      q = int'(x) / int'(y);
      r = int'(x) % int'(y);
    end
    for (int row = 0; row < 8; row++) begin
      if (app[row*8 +: 8] == 8'h00) q = q & ~(1 << (7 - row));
    end
    return {8'(q), 8'(r)};
  endfunction

  assign {bus.div_q, bus.div_r} = div_model(bus.div_x, bus.div_y, bus.div_app);

  // Reference model state
  bit          live = 1'b0;
  bit          m_rst_prev, m_busy, m_valid, m_rchk_job, acc_ok;
  int          m_cnt;
  logic [7:0]  e_q, e_r, e_err;
  logic        e_dz, e_ovf;
  logic [15:0] e_dx;
  logic [7:0]  e_dy;
  logic [63:0] e_app;
  logic [15:0] jx, apx, ex;
  logic [7:0]  jy;
  logic [2:0]  jl;

  // Compare against the model, then advance the model over the coming edge.
  always @(negedge clk) begin
    if (live) begin
      chk("in_ready", 64'(bus.in_ready), 64'(!m_busy && !m_rst_prev));
      chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("out_q", 64'(bus.out_q), 64'(e_q));
        chk("out_r", 64'(bus.out_r), 64'(e_r));
        chk("out_dz", 64'(bus.out_dz), 64'(e_dz));
        chk("out_ovf", 64'(bus.out_ovf), 64'(e_ovf));
        chk("out_err", 64'(bus.out_err), 64'(e_err));
      end else if (m_rst_prev) begin
        chk("rst_out", 64'({bus.out_q, bus.out_r, bus.out_err, bus.out_dz, bus.out_ovf}), 64'd0);
      end
      chk("div_x", 64'(bus.div_x), 64'(e_dx));
      chk("div_y", 64'(bus.div_y), 64'(e_dy));
      chk("div_app", bus.div_app, e_app);
      chk("div_bin", 64'(bus.div_bin), 64'd0);
    end
    if (rst) begin
      live = 1'b1; m_rst_prev = 1'b1; m_busy = 1'b0; m_valid = 1'b0;
      e_dx = 16'd0; e_dy = 8'd0; e_app = {64{1'b1}};
    end else if (live) begin
      acc_ok = !m_busy && !m_rst_prev;
      m_rst_prev = 1'b0;
      if (m_valid) begin
        if (bus.out_ready) begin
          m_valid = 1'b0;
          m_busy  = 1'b0;
        end
      end else if (m_busy) begin
        m_cnt--;
        if (m_rchk_job && m_cnt == S) e_app = {64{1'b1}};
        if (m_cnt == 0) m_valid = 1'b1;
      end else if (acc_ok && bus.in_valid) begin
        m_busy = 1'b1;
        jx = bus.in_x; jy = bus.in_y; jl = bus.in_level;
        m_rchk_job = RCHK && (jy != 8'd0) && (jl != 3'd0);
        if (jy == 8'd0) begin
          m_cnt = 1;
          e_q = 8'hFF; e_r = jx[7:0]; e_dz = 1'b1; e_ovf = 1'b0; e_err = 8'd0;
        end else begin
          apx = div_model(jx, jy, ref_masks(int'(jl)));
          ex  = div_model(jx, jy, {64{1'b1}});
          e_q = apx[15:8]; e_r = apx[7:0]; e_dz = 1'b0; e_ovf = (jx[15:8] >= jy);
          e_err = !m_rchk_job ? 8'd0 :
                  (ex[15:8] >= apx[15:8]) ? ex[15:8] - apx[15:8] : apx[15:8] - ex[15:8];
          m_cnt = m_rchk_job ? 2 * S : S;
          e_dx = jx; e_dy = jy; e_app = ref_masks(int'(jl));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_job(input logic [15:0] x, input logic [7:0] y, input logic [2:0] l);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1; bus.in_x = x; bus.in_y = y; bus.in_level = l;
    step();
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.in_x = 16'($urandom); bus.in_y = 8'($urandom); bus.in_level = 3'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    lat = cyc - acc_cyc;
    chk("out_valid_wait", 64'(bus.out_valid), 64'd1);
  endtask

  logic [63:0] m;
  int lat;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_x = 16'd0; bus.in_y = 8'd0; bus.in_level = 3'd0;
    bus.out_ready = 1'b0;

    // Pin the model's mask map and divider model with hand-computed values
    m = ref_masks(7);
    chk("mask_l7_app1", 64'(m[7:0]), 64'h00FE);
    chk("mask_l7_app8", 64'(m[63:56]), 64'h0000);
    m = ref_masks(1);
    chk("mask_l1_hi", 64'(m[63:48]), 64'hFCFE);
    m = ref_masks(0);
    chk("mask_l0", m, {64{1'b1}});
    chk("model_127_5_l7", 64'(div_model(16'd127, 8'd5, ref_masks(7))), 64'h1802);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_div_app", bus.div_app, {64{1'b1}});
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Exact job, consumer ready
    bus.out_ready = 1'b1;
    send_job(16'd199, 8'd7, 3'd0);
    wait_valid(lat);
    chk("t1_lat", 64'(lat), 64'd2);
    chk("t1_q", 64'(bus.out_q), 64'd28);
    chk("t1_r", 64'(bus.out_r), 64'd3);
    chk("t1_dz_ovf", 64'({bus.out_dz, bus.out_ovf}), 64'd0);

    // Level 1 with a stalled consumer
    step();
    bus.out_ready = 1'b0;
    send_job(16'd40, 8'd13, 3'd1);
    chk("t2_app_hi", 64'(bus.div_app[63:48]), 64'hFCFE);
    wait_valid(lat);
    chk("t2_lat", 64'(lat), 64'(RCHK ? 2 * S : S));
    for (int k = 0; k < 5; k++) begin
      chk("t2_hold_q", 64'(bus.out_q), 64'd3);
      chk("t2_hold_r", 64'(bus.out_r), 64'd1);
      chk("t2_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("t2_hold_in_ready", 64'(bus.in_ready), 64'd0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    chk("t2_release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("t2_release_valid", 64'(bus.out_valid), 64'd0);

    // Divide by zero
    send_job(16'd8, 8'd0, 3'd0);
    wait_valid(lat);
    chk("t3_lat", 64'(lat), 64'd1);
    chk("t3_q", 64'(bus.out_q), 64'hFF);
    chk("t3_r", 64'(bus.out_r), 64'd8);
    chk("t3_dz", 64'(bus.out_dz), 64'd1);
    step();

    // Quotient overflow flag
    send_job(16'h0500, 8'd4, 3'd0);
    wait_valid(lat);
    chk("t4_ovf", 64'(bus.out_ovf), 64'd1);
    chk("t4_dz", 64'(bus.out_dz), 64'd0);
    step();

    // Reset during SETTLE abandons the job
    send_job(16'd127, 8'd5, 3'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t5_no_valid", 64'(bus.out_valid), 64'd0);
      step();
    end
    send_job(16'd127, 8'd5, 3'd0);
    wait_valid(lat);
    chk("t5_q", 64'(bus.out_q), 64'd25);
    chk("t5_r", 64'(bus.out_r), 64'd2);
    step();

    // Level 7: approximate quotient, optional recheck error
    send_job(16'd127, 8'd5, 3'd7);
    wait_valid(lat);
    chk("t6_lat", 64'(lat), 64'(RCHK ? 2 * S : S));
    chk("t6_q", 64'(bus.out_q), 64'd24);
    chk("t6_r", 64'(bus.out_r), 64'd2);
    chk("t6_err", 64'(bus.out_err), 64'(RCHK ? 1 : 0));
    step();

    // Randomised traffic, back-pressure and occasional resets
    for (int c = 0; c < 4000; c++) begin
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_x      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047));
      bus.in_y      = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      bus.in_level  = 3'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      rst           = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2 * S + 10) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/read_div_ctrl.md
Name: read_div_ctrl

Overview:
- Sequencing controller for the 16x8 approximate array divider (dividend x[15:0], divisor y[7:0], borrow-in, per-row approximation masks app1..app8, quotient/remainder q,r).
- Accepts division jobs over a valid/ready handshake and translates a 3-bit approximation level into the eight row masks.
- Drives the combinational divider and holds its inputs stable for a settle window, then registers q/r and presents them downstream with a valid/ready handshake.
- Sits between the job source and one divider instance.

Parameters:
- SETTLE_CYCLES, 2, cycles divider inputs are held before q/r are sampled (legal 1..15).
- DZ_QUOT, 8'hFF, quotient returned for divide-by-zero.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  job request
- in_ready  out  1  controller can accept a job
- in_x  in  16  dividend
- in_y  in  8  divisor
- in_level  in  3  approximation level, 0 = exact
- div_x  out  16  to divider x
- div_y  out  8  to divider y
- div_bin  out  1  to divider bin, always 0
- div_app  out  64  row masks, app1 = [7:0] … app8 = [63:56]
- div_q  in  8  from divider q
- div_r  in  8  from divider r
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_q  out  8  quotient
- out_r  out  8  remainder
- out_dz  out  1  divide-by-zero flag
- out_ovf  out  1  quotient overflow flag (in_x[15:8] >= in_y, in_y != 0)
- out_err  out  8  |q_exact − q_approx|; 0 when the feature is off

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst is synchronous and active-high; it is sampled on the clk rising edge.
  - Reset mid-operation abandons the job, returns to IDLE and does not produce a result.
- Reset values: in_ready=0 during reset and 1 the first cycle after; out_valid=0; out_q/out_r/out_err=0; out_dz/out_ovf=0; div_x/div_y=0; div_app all ones; div_bin=0.
- States: IDLE, SETTLE, (RECHECK), DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at edge E0, latch x, y and level.
  - If y==0: go to DONE with out_q=DZ_QUOT, out_r=x[7:0], out_dz=1. out_valid rises at E0+1 and the divider is not exercised.
  - Otherwise: load counter=SETTLE_CYCLES and go to SETTLE.
- SETTLE:
  - div_* is driven from the latched operands and the level mask.
  - The counter decrements each cycle.
  - At the edge where it reaches 0 (E0+SETTLE_CYCLES), capture div_q/div_r into out_q/out_r and go to DONE. out_valid is high from that edge.
- DONE:
  - Outputs are held stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready at an edge returns to IDLE, so in_ready is high on the next cycle. No same-cycle accept in DONE.
  - Throughput is one job per SETTLE_CYCLES+2 cycles.
- Mask mapping, per row i=1..8:
  - Level 0: every mask is 8'hFF.
  - Level L ≥ 1: shift_i = max(0, i+L−7), capped at 8; mask_i = (8'hFF << shift_i) truncated to 8 bits.
  - Example, L=1: app7=8'hFE, app8=8'hFC, others 8'hFF.
  - Example, L=7: app1=8'hFE … app8=8'h00.
- div_x, div_y and div_app change only on the acceptance edge (and on RECHECK entry).
- The level is latched per job; in_level changes mid-job have no effect.
- out_ovf = (x[15:8] >= y) for y != 0. It is informational only; q is still taken from the divider.

Optional Feature:
- Macro: READ_DIV_RECHECK_EN.
- Defined:
  - After SETTLE, if the latched level != 0, the controller enters RECHECK.
  - It stores the approximate q, sets div_app all ones, waits SETTLE_CYCLES, then samples the exact q.
  - out_err = |q_exact − q_approx|. out_q/out_r report the approximate result.
  - Latency is 2·SETTLE_CYCLES.
  - Level 0 skips RECHECK and gives out_err=0.
- Undefined: the RECHECK state is not built and out_err is constantly 0.

Decomposition:
- Shared package read_div_pkg holds:
  - the state enum;
  - LEVEL_W=3, MASK_W=8, ROWS=8;
  - the DZ_QUOT default;
  - the level→mask function.
- One natural sub-module, read_div_mask_gen: a combinational map from level to the 64-bit div_app.
- The controller holds the FSM, settle counter and output registers.

Test Plan (bench models the divider: exact x/y when all masks are ones; masked rows behave per the divider model):
- Reset, then x=199, y=7, level=0, SETTLE_CYCLES=2 -> out_valid at E0+2, out_q=28, out_r=3, dz=0, ovf=0; div_app=64'hFFFF_FFFF_FFFF_FFFF throughout.
- x=40, y=13, level=1; out_ready held 0 for 5 cycles -> div_app[63:48]=16'hFCFE; outputs stable while stalled; in_ready=0 until the cycle after the out_ready handshake.
- x=8, y=0 -> out_valid at E0+1, out_q=8'hFF, out_r=8, out_dz=1.
- x=16'h0500, y=4 -> out_ovf=1.
- rst asserted during SETTLE of x=127, y=5 -> out_valid stays 0, state returns to IDLE, next job x=127, y=5 returns q=25, r=2.
- READ_DIV_RECHECK_EN, x=127, y=5, level=7 with a model giving approximate q=24 -> out_q=24, out_err=1, out_valid at E0+4.
